// File: rtl/gray_pkg.sv
// Shared Gray-code helpers: reference converters and the per-stage slicing rule
// used by the pipelined decoder, its assertions and the bin2gray/gray2bin benches.
package gray_pkg;

    localparam int MAX_W = 64;

    typedef struct packed {
        int hi;
        int lo;
    } bounds_t;

    function automatic logic [63:0] gray2bin_f(input logic [63:0] g);
        logic [63:0] b;
        b[63] = g[63];
        for (int i = 62; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [63:0] bin2gray_f(input logic [63:0] b);
        return b ^ (b >> 1);
    endfunction

    // An empty slice (more stages than chunks) comes back as hi=-1, lo=0.
    function automatic bounds_t chunk_bounds(input int width, input int stages, input int k);
        int      chunk;
        bounds_t r;
        chunk = (stages < 1) ? width : (width + stages - 1) / stages;
        r.hi  = width - 1 - k * chunk;
        r.lo  = width - (k + 1) * chunk;
        if (r.lo < 0) begin
            r.lo = 0;
        end
        if (r.hi < 0) begin
            r.hi = -1;
            r.lo = 0;
        end
        return r;
    endfunction

endpackage

// File: rtl/gray2bin_stage.sv
// One registered slice of the Gray decoder: resolves bits [HI:LO] of the word and
// carries a valid/ready skid-free handshake stage (ready = empty or downstream ready).
module gray2bin_stage
    import gray_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int HI    = 31,
    parameter int LO    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_data
);

    if (WIDTH > MAX_W) begin : g_bad_width
        $error("gray2bin_stage: WIDTH exceeds MAX_W");
    end

    logic             valid;
    logic [WIDTH-1:0] data;

    // Bits above HI are already binary, so r[HI+1] seeds this slice's chain.
    function automatic logic [WIDTH-1:0] resolve(input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] r;
        r = w;
        for (int j = WIDTH - 2; j >= 0; j--) begin
            if (j <= HI && j >= LO) begin
                r[j] = r[j+1] ^ w[j];
            end
        end
        return r;
    endfunction

    assign up_ready = !valid || dn_ready;
    assign dn_valid = valid;
    assign dn_data  = data;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (up_ready) begin
            valid <= up_valid;
            if (up_valid) begin
                data <= resolve(up_data);
            end
        end
    end

endmodule

// File: rtl/gray2bin_pipe.sv
// Pipelined Gray-to-binary decoder: the serial XOR prefix chain is cut into STAGES
// registered slices, each with its own valid/ready so bubbles collapse under stall.
module gray2bin_pipe
    import gray_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] gray_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] bin_out
);

    if (WIDTH < 2 || WIDTH > MAX_W || STAGES < 1 || STAGES > WIDTH) begin : g_bad_cfg
        $error("gray2bin_pipe: illegal WIDTH/STAGES combination");
    end

    // Per-stage nets live inside each generate block so the ready chain is a
    // set of distinct signals rather than one self-referencing array.
    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam bounds_t BND = chunk_bounds(WIDTH, STAGES, k);

        logic             up_valid;
        logic             up_ready;
        logic [WIDTH-1:0] up_data;
        logic             dn_valid;
        logic             dn_ready;
        logic [WIDTH-1:0] dn_data;

        if (k == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = gray_in;
        end else begin : g_body
            assign up_valid = stg[k-1].dn_valid;
            assign up_data  = stg[k-1].dn_data;
        end

        if (k == STAGES - 1) begin : g_tail
            assign dn_ready = out_ready;
        end else begin : g_link
            assign dn_ready = stg[k+1].up_ready;
        end

        gray2bin_stage #(
            .WIDTH (WIDTH),
            .HI    (BND.hi),
            .LO    (BND.lo)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .up_valid (up_valid),
            .up_ready (up_ready),
            .up_data  (up_data),
            .dn_valid (dn_valid),
            .dn_ready (dn_ready),
            .dn_data  (dn_data)
        );
    end

    assign in_ready  = stg[0].up_ready;
    assign out_valid = stg[STAGES-1].dn_valid;
    assign bin_out   = stg[STAGES-1].dn_data;

    a_out_hold : assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(bin_out)))
        else $error("gray2bin_pipe: output changed while stalled");

    a_full_blocks : assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready && in_ready) |-> !stg[0].dn_valid || (STAGES > 1))
        else $error("gray2bin_pipe: single-stage pipe accepted while full");

endmodule

// File: tb/tb_gray2bin_pipe.sv
// Directed and random scoreboard bench for gray2bin_pipe across several WIDTH/STAGES
// configurations; one selected instance is driven at a time, the rest idle.
module tb_gray2bin_pipe;
    import gray_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [63:0] gray = '0;
    logic [2:0]  sel = 3'd0;

    always #5 clk = ~clk;

    logic [5:0]  iv, orr, ir, ov;
    logic [7:0]  bo0, bo1, bo2, bo3;
    logic [31:0] bo4;
    logic [32:0] bo5;
    logic        obs_ir, obs_ov;
    logic [63:0] obs_bin;

    always_comb begin
        iv  = '0;
        orr = '1;
        case (sel)
            3'd0: begin iv[0] = in_valid; orr[0] = out_ready; end
            3'd1: begin iv[1] = in_valid; orr[1] = out_ready; end
            3'd2: begin iv[2] = in_valid; orr[2] = out_ready; end
            3'd3: begin iv[3] = in_valid; orr[3] = out_ready; end
            3'd4: begin iv[4] = in_valid; orr[4] = out_ready; end
            default: begin iv[5] = in_valid; orr[5] = out_ready; end
        endcase
    end

    always_comb begin
        obs_ir  = 1'b0;
        obs_ov  = 1'b0;
        obs_bin = '0;
        case (sel)
            3'd0: begin obs_ir = ir[0]; obs_ov = ov[0]; obs_bin = {56'b0, bo0}; end
            3'd1: begin obs_ir = ir[1]; obs_ov = ov[1]; obs_bin = {56'b0, bo1}; end
            3'd2: begin obs_ir = ir[2]; obs_ov = ov[2]; obs_bin = {56'b0, bo2}; end
            3'd3: begin obs_ir = ir[3]; obs_ov = ov[3]; obs_bin = {56'b0, bo3}; end
            3'd4: begin obs_ir = ir[4]; obs_ov = ov[4]; obs_bin = {32'b0, bo4}; end
            default: begin obs_ir = ir[5]; obs_ov = ov[5]; obs_bin = {31'b0, bo5}; end
        endcase
    end

    gray2bin_pipe #(.WIDTH(8), .STAGES(4)) u0 (.clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .gray_in(gray[7:0]), .out_valid(ov[0]), .out_ready(orr[0]), .bin_out(bo0));
    gray2bin_pipe #(.WIDTH(8), .STAGES(1)) u1 (.clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .gray_in(gray[7:0]), .out_valid(ov[1]), .out_ready(orr[1]), .bin_out(bo1));
    gray2bin_pipe #(.WIDTH(8), .STAGES(3)) u2 (.clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .gray_in(gray[7:0]), .out_valid(ov[2]), .out_ready(orr[2]), .bin_out(bo2));
    gray2bin_pipe #(.WIDTH(8), .STAGES(8)) u3 (.clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]),
        .gray_in(gray[7:0]), .out_valid(ov[3]), .out_ready(orr[3]), .bin_out(bo3));
    gray2bin_pipe #(.WIDTH(32), .STAGES(5)) u4 (.clk(clk), .rst(rst), .in_valid(iv[4]), .in_ready(ir[4]),
        .gray_in(gray[31:0]), .out_valid(ov[4]), .out_ready(orr[4]), .bin_out(bo4));
    gray2bin_pipe #(.WIDTH(33), .STAGES(4)) u5 (.clk(clk), .rst(rst), .in_valid(iv[5]), .in_ready(ir[5]),
        .gray_in(gray[32:0]), .out_valid(ov[5]), .out_ready(orr[5]), .bin_out(bo5));

    typedef struct {
        logic [63:0] val;
        int          t;
    } ent_t;

    ent_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          cur_lat = 0;
    bit          lat_chk = 1'b0;
    bit          last_acc = 1'b0;
    logic [63:0] next_exp = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Inputs are set at the falling edge; sampling happens 1 unit later.
    task automatic tick();
        ent_t e;
        #1;
        last_acc = !rst && in_valid && obs_ir;
        if (!rst && obs_ov && out_ready) begin
            chk("out_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("bin_out", obs_bin, e.val);
                if (lat_chk) begin
                    chk("latency", 64'(cyc - e.t), 64'(cur_lat));
                end
            end
        end
        if (last_acc) begin
            sb.push_back('{next_exp, cyc});
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic push(input logic [63:0] g, input logic [63:0] exp);
        gray     = g;
        next_exp = exp;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (last_acc) break;
        end
        chk("push_accept", 64'(last_acc), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            tick();
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          c0;
        int          pushed;
        logic [63:0] held;
        bit          seen;
        int          lat_tab[4] = '{4, 1, 3, 8};

        // Reset state across all instances
        @(negedge clk);
        tick();
        tick();
        chk("rst_in_ready", 64'(ir), 64'h3f);
        rst = 1'b0;
        tick();
        chk("rst_out_valid", 64'(ov), 64'h0);
        chk("rst_bin_8", {bo0, bo1, bo2, bo3}, 64'h0);
        chk("rst_bin_32", 64'(bo4), 64'h0);
        chk("rst_bin_33", 64'(bo5), 64'h0);

        // Basic latency/throughput, W=8 S=4
        sel = 3'd0; out_ready = 1'b1; lat_chk = 1'b1; cur_lat = 4;
        push(64'h80, 64'hFF);
        push(64'h00, 64'h00);
        push(64'h0C, 64'h08);
        drain();

        // Full 8-bit sweep back-to-back for several stage counts
        for (int s = 1; s <= 3; s++) begin
            sel = 3'(s);
            cur_lat = lat_tab[s];
            c0 = cyc;
            for (int v = 0; v < 256; v++) begin
                push(bin2gray_f(64'(v)), 64'(v));
            end
            chk("b2b_cycles", 64'(cyc - c0), 64'd256);
            drain();
        end

        // Stall with in_valid held high
        sel = 3'd0; lat_chk = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
        n = 0; seen = 1'b0; held = '0;
        for (int i = 0; i < 10; i++) begin
            gray     = bin2gray_f(64'(100 + n));
            next_exp = 64'(100 + n);
            tick();
            if (last_acc) n++;
            if (!seen && obs_ov) begin
                seen = 1'b1;
                held = obs_bin;
            end
        end
        chk("stall_accepts", 64'(n), 64'd4);
        chk("stall_in_ready", 64'(obs_ir), 64'd0);
        chk("stall_out_valid", 64'(obs_ov), 64'd1);
        chk("stall_bin_hold", obs_bin, held);
        chk("stall_bin_first", obs_bin, 64'd100);
        drain();

        // Random handshake, W=32 S=5
        sel = 3'd4; pushed = 0;
        for (int i = 0; i < 50000 && pushed < 10000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            gray      = {32'h0, $urandom};
            next_exp  = gray2bin_f(gray);
            out_ready = 1'($urandom_range(0, 1));
            tick();
            if (last_acc) pushed++;
        end
        chk("rand_pushed", 64'(pushed), 64'd10000);
        drain();

        // Reset with three words in flight
        sel = 3'd0; out_ready = 1'b0;
        push(64'h11, 64'h1E);
        push(64'h22, 64'h3C);
        push(64'h33, 64'h22);
        rst = 1'b1; in_valid = 1'b1; gray = 64'h55;
        tick();
        sb.delete();
        rst = 1'b0; in_valid = 1'b0;
        chk("midrst_out_valid", 64'(obs_ov), 64'd0);
        chk("midrst_bin", obs_bin, 64'h0);
        out_ready = 1'b1; lat_chk = 1'b1; cur_lat = 4;
        push(64'h0F, 64'h0A);
        drain();
        for (int i = 0; i < 8; i++) tick();

        // Uneven slicing, W=33 S=4
        sel = 3'd5; cur_lat = 4;
        push(64'h1_0000_0000, 64'h1_FFFF_FFFF);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gray2bin_pipe.md
Name: gray2bin_pipe

Overview:
Pipelined Gray-code-to-binary decoder; the inverse of the team's combinational bin2gray converter. The decode is a serial XOR prefix chain (bin[i] = bin[i+1] ^ gray[i]) of depth WIDTH, so it is split into STAGES registered slices to meet timing at wide WIDTH. It sits on the read side of Gray-coded pointer/counter paths, such as async FIFO pointers after synchronisation and Gray-coded position counters. It carries a valid/ready stream handshake with full throughput and back-pressure.

Parameters:
WIDTH, 32, data width in bits; legal range 2..64.
STAGES, 4, number of register stages, equal to latency in cycles; legal range 1..WIDTH; out-of-range values are a static assertion (elaboration error).

Ports:
clk  input  1  clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  gray_in is valid this cycle.
in_ready  output  1  block accepts gray_in this cycle.
gray_in  input  WIDTH  Gray-coded input word.
out_valid  output  1  bin_out is valid.
out_ready  input  1  downstream accepts bin_out this cycle.
bin_out  output  WIDTH  decoded binary word.

Behaviour:
- Reset (rst=1 at a clk edge): all stage valid flags cleared; all stage data registers cleared to 0. Consequences: out_valid=0 and bin_out=0 the cycle after reset. in_ready is 1 while rst is held, because all stages are empty.
- Slicing:
  - CHUNK = ceil(WIDTH/STAGES).
  - Stage k (k=0 at the input side) resolves binary bits [WIDTH-1-k*CHUNK : max(0, WIDTH-(k+1)*CHUNK)].
  - Stages whose range is empty pass data through unchanged but are still registered.
  - Within a chunk, bits are resolved MSB to LSB: bin[j] = bin[j+1] ^ gray[j]. The top bit of stage 0 is bin[WIDTH-1] = gray[WIDTH-1].
  - The seed for the top bit of each later chunk is the lowest resolved bit of the previous stage.
- Stage register content: each stage register holds one WIDTH-bit word, with resolved binary bits above the boundary and still-Gray bits below it.
- Handshake per stage k:
  - ready_k = !valid_k || ready_{k+1}, with ready_STAGES = out_ready.
  - Stage k loads when ready_k is high, and its valid becomes the upstream valid.
  - A stage not loading holds both data and valid.
  - in_ready = ready_0. out_valid = valid_{STAGES-1}. bin_out = data_{STAGES-1}.
- Transfers: occur on in_valid&in_ready and on out_valid&out_ready, AXI-stream style.
  - in_ready may depend combinationally on out_ready.
  - No output depends combinationally on in_valid or gray_in.
- Latency: an accepted word appears at out_valid exactly STAGES cycles later if never stalled.
- Throughput: one word per cycle while out_ready=1.
- Full pipeline: with all STAGES valid and out_ready=0, in_ready=0. Exactly STAGES words are held; no word is lost or duplicated.
- Simultaneous events:
  - Pop and push in the same cycle on a full pipeline: both complete, and occupancy is unchanged.
  - Bubbles are collapsed: an empty stage accepts even if downstream is stalled.
- out_valid stability: once asserted, out_valid and bin_out stay stable until out_ready=1.
- Reset mid-operation: all in-flight words are discarded and no partial word emerges. in_valid during rst is ignored; nothing is captured on a reset edge.

Decomposition:
- Package gray_pkg:
  - Function gray2bin_f(logic[63:0]), a combinational reference used by the bench and by assertions.
  - Function chunk_bounds(width, stages, k), which returns the hi/lo bit indices of stage k.
  - Shared with bin2gray benches.
- One sub-module, gray2bin_stage:
  - Parameters WIDTH, HI, LO.
  - Holds one data register plus valid and the ready logic.
  - Generated STAGES times by the top level.

Test Plan:
1. WIDTH=8, STAGES=4, out_ready=1: push 0x80, 0x00, 0x0C on consecutive cycles -> bin_out is 0xFF, 0x00, 0x08 on cycles 4, 5, 6 after the first accept, with out_valid high for 3 consecutive cycles.
2. WIDTH=8, STAGES in {1, 3, 8}: push all 256 words bin2gray(0..255) back-to-back -> outputs are 0..255 in order, first output at latency STAGES, and zero idle cycles.
3. WIDTH=8, STAGES=4, out_ready=0 for 10 cycles with in_valid held high -> exactly 4 accepts, then in_ready=0. out_valid and bin_out stay stable while stalled. After out_ready=1, all words emerge in order with none dropped.
4. Random in_valid/out_ready at 50% each, WIDTH=32, STAGES=5, 10k words -> scoreboard matches gray2bin_f on every output, in order.
5. Pipeline holding 3 words, assert rst for 1 cycle -> next cycle out_valid=0 and bin_out=0. A new word pushed after reset emerges alone after STAGES cycles.
6. WIDTH=33, STAGES=4 (CHUNK=9, last stage resolves 6 bits): push gray 33'h1_0000_0000 -> bin_out=33'h1_FFFF_FFFF.
